// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-channel TDM receive path.
// Optional sticky framing error is enabled by defining TDM_ERR_EN.
package tdm_pkg;

  localparam int TDM_WIDTH    = 16;
  localparam int TDM_CHANNELS = 8;
  localparam int TDM_SEL_W    = 3;

  typedef enum logic {
    IDLE,
    RECV
  } tdm_state_t;

  typedef logic [TDM_WIDTH-1:0] tdm_word_t;

endpackage

// File: rtl/DMux8Way.sv
// 1-to-8 demultiplexer: sel 000 routes din to dout[7],
// sel 111 routes it to dout[0].
module DMux8Way (
  input  logic       din,
  input  logic [2:0] sel,
  output logic [7:0] dout
);

  always_comb begin
    dout = '0;
    dout[3'd7 - sel] = din;
  end

endmodule

// File: rtl/tdm_demux8_16.sv
// Receive-side TDM demultiplexer: 8 framed words to 8 committed channels.
// Define TDM_ERR_EN to add i_err_clr and the sticky o_err framing flag.
module tdm_demux8_16
  import tdm_pkg::*;
#(
  parameter  int WIDTH    = TDM_WIDTH,
  parameter  int CHANNELS = TDM_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic                      i_sof,
  input  logic [WIDTH-1:0]          i_data,
`ifdef TDM_ERR_EN
  input  logic                      i_err_clr,
`endif
  output logic [CHANNELS*WIDTH-1:0] o_ch,
  output logic                      o_frame_done,
  output logic [SEL_W-1:0]          o_slot,
  output logic                      o_err
);

  tdm_state_t state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] ch_q;
  logic done_q;

  logic dmux_in;
  logic [2:0] dmux_sel;
  logic [7:0] load_dmux;
  logic [CHANNELS-1:0] load;
  logic last;

  // A start-of-frame beat always lands in slot 0, even mid-frame.
  assign dmux_in  = i_valid & ((state_q == RECV) | i_sof);
  assign dmux_sel = i_sof ? 3'd0 : 3'(slot_q);

  DMux8Way u_dmux (
    .din  (dmux_in),
    .sel  (dmux_sel),
    .dout (load_dmux)
  );

  always_comb begin
    load = '0;
    for (int k = 0; k < CHANNELS; k++)
      load[k] = load_dmux[CHANNELS-1-k];
  end

  assign last = (state_q == RECV) & i_valid & ~i_sof
              & (slot_q == SEL_W'(CHANNELS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid & i_sof) begin
          state_d = RECV;
          slot_d  = SEL_W'(1);
        end
      end
      RECV: begin
        if (i_valid) begin
          if (i_sof) begin
            slot_d = SEL_W'(1);
          end else if (last) begin
            state_d = IDLE;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SEL_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++)
        shadow[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (load[k]) shadow[k] <= i_data;
    end
  end

  // Commit merges the in-flight last beat with the stored shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (last) begin
        for (int k = 0; k < CHANNELS; k++)
          ch_q[WIDTH*k +: WIDTH] <= load[k] ? i_data : shadow[k];
      end
    end
  end

`ifdef TDM_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = i_valid
                 & ((state_q == IDLE) ? ~i_sof : i_sof);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_set | (err_q & ~i_err_clr);
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_ch         = ch_q;
  assign o_frame_done = done_q;
  assign o_slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux8_16.sv
// Bench for tdm_demux8_16: directed scenarios plus random beats
// checked against a queue-based frame model.
module tb_tdm_demux8_16;
  import tdm_pkg::*;

`ifdef TDM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_sof = 1'b0;
  logic i_err_clr = 1'b0;
  logic [15:0] i_data = '0;
  logic [127:0] o_ch;
  logic o_frame_done;
  logic [2:0] o_slot;
  logic o_err;

  int n_chk = 0;
  int n_fail = 0;

  tdm_word_t q[$];
  logic [127:0] m_ch;
  logic m_done;
  logic m_err;

  always #5 clk = ~clk;

  tdm_demux8_16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_sof        (i_sof),
    .i_data       (i_data),
`ifdef TDM_ERR_EN
    .i_err_clr    (i_err_clr),
`endif
    .o_ch         (o_ch),
    .o_frame_done (o_frame_done),
    .o_slot       (o_slot),
    .o_err        (o_err)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ch = '0;
    m_done = 1'b0;
    m_err = 1'b0;
  endtask

  // Frame model: a frame is the list of words since the last sof.
  task automatic model_update(input logic v, input logic s,
                              input logic [15:0] d, input logic c);
    logic set;
    set = 1'b0;
    m_done = 1'b0;
    if (v) begin
      if (s) begin
        if (q.size() != 0) set = 1'b1;
        q.delete();
        q.push_back(d);
      end else if (q.size() == 0) begin
        set = 1'b1;
      end else begin
        q.push_back(d);
        if (q.size() == 8) begin
          for (int k = 0; k < 8; k++)
            m_ch[16*k +: 16] = q[k];
          m_done = 1'b1;
          q.delete();
        end
      end
    end
    m_err = set | (m_err & ~c);
  endtask

  task automatic check_all();
    chk("o_ch", o_ch, m_ch);
    chk("o_frame_done", o_frame_done, m_done);
    chk("o_slot", o_slot, q.size());
    chk("o_err", o_err, ERR_EN ? m_err : 1'b0);
  endtask

  task automatic step(input logic v, input logic s,
                      input logic [15:0] d, input logic c);
    @(negedge clk);
    i_valid = v;
    i_sof = s;
    i_data = d;
    i_err_clr = c;
    @(posedge clk);
    model_update(v, s, d, c);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [127:0] exp_clean;
    logic [127:0] exp_resync;
    exp_clean = {16'd8, 16'd7, 16'd6, 16'd5,
                 16'd4, 16'd3, 16'd2, 16'd1};
    exp_resync = {16'h0088, 16'h0077, 16'h0066, 16'h0055,
                  16'h0044, 16'h0033, 16'h0022, 16'h0011};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++)
      step(1'b1, k == 0, 16'(k + 1), 1'b0);
    chk("clean_ch", o_ch, exp_clean);
    chk("clean_done", o_frame_done, 1'b1);
    idle(1);
    chk("clean_done_drop", o_frame_done, 1'b0);

    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 0, 16'(k + 1), 1'b0);
      if (k != 7) idle(2);
    end
    chk("gapped_ch", o_ch, exp_clean);
    idle(1);

    for (int k = 0; k < 5; k++)
      step(1'b1, k == 0, 16'hAAAA, 1'b0);
    step(1'b1, 1'b1, 16'h0011, 1'b0);
    chk("resync_hold", o_ch, exp_clean);
    chk("resync_err", o_err, ERR_EN);
    for (int k = 2; k <= 8; k++)
      step(1'b1, 1'b0, 16'(k * 16'h11), 1'b0);
    chk("resync_ch", o_ch, exp_resync);
    idle(1);

    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk("orphan_ch", o_ch, exp_resync);
    chk("orphan_err", o_err, ERR_EN);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("clr_err", o_err, 1'b0);
    step(1'b1, 1'b0, 16'hBEEF, 1'b1);
    chk("set_wins", o_err, ERR_EN);
    step(1'b0, 1'b0, 16'h0, 1'b1);

    for (int k = 0; k < 4; k++)
      step(1'b1, k == 0, 16'h1234 + 16'(k), 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ch", o_ch, 128'h0);
    chk("rst_slot", o_slot, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      step(1'b1, k == 0, 16'h0100 + 16'(k), 1'b0);
    chk("post_rst_done", o_frame_done, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      logic v, s, c;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 19) == 0);
      step(v, s, 16'($urandom), c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux8_16.md
# tdm_demux8_16

Receive-side time-division demultiplexer for the shared 16-bit bus driven by the Mux8Way16-based TDM transmitter.

- Accepts a framed stream of 8 words, one per `i_valid` beat, starting at the beat marked `i_sof`.
- Routes each word into a per-channel shadow register, then commits all 8 channels to the outputs at once when the frame completes.
- Sits at the far end of the 8-channel link and restores the channel set that the sender's select counter walked through.

## Interface

Parameters:
- `WIDTH`, 16: word width per channel.
- `CHANNELS`, 8: channels per frame. Fixed to a power of two; `SEL_W = $clog2(CHANNELS)`.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_valid`  in  1: the current beat carries a word.
- `i_sof`  in  1: start of frame. Meaningful only when `i_valid`=1; marks slot 0.
- `i_data`  in  WIDTH: beat payload.
- `i_err_clr`  in  1: clears the sticky `o_err`. Present only with `TDM_ERR_EN`.
- `o_ch`  out  CHANNELS*WIDTH: committed channel words. Channel k occupies `[WIDTH*k+WIDTH-1 : WIDTH*k]`; slot 0 maps to channel 0 (sender input `a`).
- `o_frame_done`  out  1: one-cycle pulse when a commit occurs.
- `o_slot`  out  SEL_W: slot expected on the next beat.
- `o_err`  out  1: sticky framing error.

## Operation

State machine: IDLE, RECV.

- **IDLE**
  - `i_valid & i_sof`: write `i_data` to shadow[0], `o_slot` becomes 1, go to RECV.
  - `i_valid & ~i_sof`: beat discarded, no state change, `o_err` set (orphan beat).
- **RECV**
  - `i_valid & ~i_sof`: write shadow[`o_slot`], then `o_slot` increments.
  - Beat arriving while `o_slot`=CHANNELS-1 is the last beat. It completes the frame: all shadows, with this beat written in place, are copied into the `o_ch` registers; `o_frame_done` pulses; `o_slot` wraps to 0; go to IDLE.
  - `i_valid & i_sof`: mid-frame resync.
    - Set `o_err`.
    - Discard the partial shadow frame; `o_ch` is not updated.
    - Treat the beat as slot 0 of a new frame: shadow[0] is written, `o_slot` becomes 1, stay in RECV.
  - `i_valid`=0: hold all state. Gaps between beats are unbounded.
- Shadow load enables come from decoding `o_slot` one-hot, gated by `i_valid`.
- `o_ch` changes only on commit. Partial frames are never visible at the outputs.
- `o_err`:
  - Set by an orphan beat or by a mid-frame resync.
  - Cleared by `i_err_clr`.
  - If a set event and `i_err_clr` occur in the same cycle, the set wins.
- `i_sof` on the last slot position is a resync: the frame is not committed.

## Timing

- Reset values: `o_ch`=0, `o_frame_done`=0, `o_slot`=0, `o_err`=0, state IDLE, shadows=0.
- Reset is asserted and released asynchronously. Asserting it mid-frame drops the partial frame immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Last beat sampled at edge N: `o_ch` holds the new frame and `o_frame_done`=1 in cycle N..N+1. `o_frame_done` returns to 0 at edge N+1 unless another commit occurs.
- Minimum frame length is 8 consecutive cycles, so back-to-back frames give one commit every 8 cycles.
- An `i_sof` beat directly after a last beat is accepted in the following cycle with no bubble.
- `o_slot` updates at the same edge as the shadow write.

## Configuration

- `TDM_ERR_EN` defined:
  - `i_err_clr` port exists.
  - The `o_err` sticky logic is implemented as described in Operation.
- `TDM_ERR_EN` undefined:
  - `i_err_clr` is absent.
  - `o_err` is tied to 0.
  - Resync and orphan-discard behaviour is unchanged.

## Structure

- Package `tdm_pkg` holds:
  - `TDM_WIDTH`=16, `TDM_CHANNELS`=8, `TDM_SEL_W`=3.
  - `typedef enum logic {IDLE, RECV} tdm_state_t`.
  - `typedef logic [TDM_WIDTH-1:0] tdm_word_t`.
- One sub-module: the existing `DMux8Way` decodes `o_slot` into load enables.
  - Its output bit 7 corresponds to sel `000`, so `DMux8Way` output bit 7-k is the load enable for shadow[k].
  - The `DMux8Way` input is driven by `i_valid` while the state is RECV, or by `i_valid & i_sof`.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles → `o_ch`=0, `o_slot`=0, `o_err`=0, `o_frame_done`=0.
- **Clean frame:** `i_sof` with 1, then 2..8 on consecutive `i_valid` beats → one cycle after beat 8, channel k = k+1; `o_frame_done` high for exactly 1 cycle; `o_err`=0.
- **Gapped frame:** same words with 2 idle cycles between each beat → identical `o_ch`; `o_ch` unchanged until after beat 8.
- **Resync:** send 5 beats of 16'hAAAA, then `i_sof` with 16'h0011 followed by 7 beats 16'h0022..16'h0088 →
  - `o_ch` keeps the previous frame until the new commit, then holds 11,22..88.
  - `o_err`=1 (`TDM_ERR_EN`), or 0 (macro undefined).
- **Orphan and clear:** in IDLE, `i_valid` with 16'hDEAD and no `i_sof` → `o_ch` unchanged, `o_err`=1. Then `i_err_clr`=1 alone → `o_err`=0. Then `i_err_clr` in the same cycle as another orphan → `o_err` remains 1.
- **Reset mid-frame:** after 4 beats, pulse `rst_n` low between clock edges → `o_ch`=0 immediately; the next `i_sof` frame of 8 words commits correctly.
